// File: rtl/saturn_mem_pkg.sv
// Shared types and constants for the external memory port arbiter.
package saturn_mem_pkg;

   typedef enum logic [1:0] {
      ROM  = 2'd0,
      RAML = 2'd1,
      RAMH = 2'd2,
      RSVD = 2'd3
   } region_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic [31:0] DEAD_READ = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin grant; search starts at the port after the last one served.
module rr_arb3 (
   input  logic [2:0] req,
   input  logic [1:0] last,
   output logic [2:0] gnt,
   output logic [1:0] idx
);

   logic [2:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = last;
      cand = '0;
      for (int i = 1; i <= 3; i++) begin
         cand = ({1'b0, last} + 3'(i)) % 3'd3;
         if (gnt == 3'b000 && req[cand[1:0]]) begin
            gnt[cand[1:0]] = 1'b1;
            idx            = cand[1:0];
         end
      end
   end

endmodule

// File: rtl/wram_mem_arbiter.sv
// Serialises MSH/SSH/DMA accesses onto the shared BIOS ROM / work RAM port,
// one single-beat cycle at a time, with a timeout guard on MEM_RDY.
module wram_mem_arbiter
   import saturn_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT       = 255,
   parameter bit          ROM_WR_IGNORE = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        P0_REQ,
   input  logic        P0_WE,
   input  logic [1:0]  P0_SEL,
   input  logic [24:0] P0_A,
   input  logic [31:0] P0_D,
   input  logic [3:0]  P0_DQM_N,
   output logic [31:0] P0_Q,
   output logic        P0_ACK,
   input  logic        P1_REQ,
   input  logic        P1_WE,
   input  logic [1:0]  P1_SEL,
   input  logic [24:0] P1_A,
   input  logic [31:0] P1_D,
   input  logic [3:0]  P1_DQM_N,
   output logic [31:0] P1_Q,
   output logic        P1_ACK,
   input  logic        P2_REQ,
   input  logic        P2_WE,
   input  logic [1:0]  P2_SEL,
   input  logic [24:0] P2_A,
   input  logic [31:0] P2_D,
   input  logic [3:0]  P2_DQM_N,
   output logic [31:0] P2_Q,
   output logic        P2_ACK,
   output logic [24:0] MEM_A,
   output logic [31:0] MEM_DO,
   input  logic [31:0] MEM_DI,
   output logic [3:0]  MEM_DQM_N,
   output logic        MEM_RD_N,
   output logic        MEM_WR_N,
   output logic        ROM_CS_N,
   output logic        RAML_CS_N,
   output logic        RAMH_CS_N,
   input  logic        MEM_RDY,
   output logic        TO_ERR
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   arb_state_t       state_q;
   logic [1:0]       last_q;
   logic [1:0]       idx_q;
   logic             we_q;
   logic [24:0]      mem_a_q;
   logic [31:0]      mem_do_q;
   logic [3:0]       mem_dqm_n_q;
   logic             rd_n_q;
   logic             wr_n_q;
   logic [2:0]       cs_n_q;
   logic [7:0]       cnt_q;
   logic [2:0]       ack_q;
   logic [2:0][31:0] q_q;
   logic             to_err_q;

   logic [2:0]  req_v;
   logic [2:0]  gnt_vec;
   logic [1:0]  gnt_idx;
   logic        g_we;
   region_t     g_sel;
   logic [24:0] g_a;
   logic [31:0] g_d;
   logic [3:0]  g_dqm_n;

   assign req_v = {P2_REQ, P1_REQ, P0_REQ};

   rr_arb3 u_arb (
      .req  (req_v),
      .last (last_q),
      .gnt  (gnt_vec),
      .idx  (gnt_idx)
   );

   always_comb begin
      g_we    = P0_WE;
      g_sel   = region_t'(P0_SEL);
      g_a     = P0_A;
      g_d     = P0_D;
      g_dqm_n = P0_DQM_N;
      case (gnt_idx)
         2'd1: begin
            g_we    = P1_WE;
            g_sel   = region_t'(P1_SEL);
            g_a     = P1_A;
            g_d     = P1_D;
            g_dqm_n = P1_DQM_N;
         end
         2'd2: begin
            g_we    = P2_WE;
            g_sel   = region_t'(P2_SEL);
            g_a     = P2_A;
            g_d     = P2_D;
            g_dqm_n = P2_DQM_N;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q     <= IDLE;
         last_q      <= 2'd2;
         idx_q       <= 2'd0;
         we_q        <= 1'b0;
         mem_a_q     <= '0;
         mem_do_q    <= '0;
         mem_dqm_n_q <= 4'hF;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         cs_n_q      <= 3'b111;
         cnt_q       <= '0;
         ack_q       <= '0;
         q_q         <= '0;
         to_err_q    <= 1'b0;
      end else if (CE_R) begin
         ack_q <= '0;
         case (state_q)
            IDLE: begin
               if (|req_v) begin
                  idx_q       <= gnt_idx;
                  we_q        <= g_we;
                  mem_a_q     <= g_a;
                  mem_do_q    <= g_d;
                  mem_dqm_n_q <= g_dqm_n;
                  if (g_sel == RSVD) begin
                     q_q[gnt_idx] <= DEAD_READ;
                     ack_q        <= gnt_vec;
                     state_q      <= DONE;
                  end else if (g_sel == ROM && g_we && ROM_WR_IGNORE) begin
                     ack_q   <= gnt_vec;
                     state_q <= DONE;
                  end else begin
                     // Strobes are registered so they appear in the ISSUE cycle.
                     cs_n_q  <= ~(3'b001 << g_sel);
                     rd_n_q  <= g_we;
                     wr_n_q  <= ~g_we;
                     state_q <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (MEM_RDY || cnt_q == TO_LAST) begin
                  cs_n_q  <= 3'b111;
                  rd_n_q  <= 1'b1;
                  wr_n_q  <= 1'b1;
                  ack_q   <= 3'b001 << idx_q;
                  state_q <= DONE;
                  if (MEM_RDY) begin
                     if (!we_q) q_q[idx_q] <= MEM_DI;
                  end else begin
                     q_q[idx_q] <= DEAD_READ;
                     to_err_q   <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            DONE: begin
               last_q  <= idx_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign P0_Q      = q_q[0];
   assign P1_Q      = q_q[1];
   assign P2_Q      = q_q[2];
   assign P0_ACK    = ack_q[0];
   assign P1_ACK    = ack_q[1];
   assign P2_ACK    = ack_q[2];
   assign MEM_A     = mem_a_q;
   assign MEM_DO    = mem_do_q;
   assign MEM_DQM_N = mem_dqm_n_q;
   assign MEM_RD_N  = rd_n_q;
   assign MEM_WR_N  = wr_n_q;
   assign ROM_CS_N  = cs_n_q[0];
   assign RAML_CS_N = cs_n_q[1];
   assign RAMH_CS_N = cs_n_q[2];
   assign TO_ERR    = to_err_q;

endmodule

// File: tb/tb_wram_mem_arbiter.sv
// Directed bench for wram_mem_arbiter: reset, round-robin order, read/write
// strobes, skipped cycles, timeout and asynchronous reset mid-cycle.
module tb_wram_mem_arbiter;

   logic             clk;
   logic             rst_n;
   logic             ce_r;
   logic [2:0]       req;
   logic [2:0]       we;
   logic [2:0][1:0]  sel;
   logic [2:0][24:0] a;
   logic [2:0][31:0] d;
   logic [2:0][3:0]  dqm_n;
   wire  [2:0][31:0] q;
   wire  [2:0]       ack;
   wire  [24:0]      mem_a;
   wire  [31:0]      mem_do;
   wire  [31:0]      mem_di;
   wire  [3:0]       mem_dqm_n;
   wire              mem_rd_n, mem_wr_n, rom_cs_n, raml_cs_n, ramh_cs_n, to_err;
   wire              strobes_idle;
   logic             mem_rdy;
   logic             di_from_a;
   logic [31:0]      di_fixed;
   logic             watch;
   logic             saw_strobe;
   int               n_checks;
   int               n_errors;

   function automatic logic [31:0] di_of(input logic [24:0] x);
      return {7'h0, x} ^ 32'hA500_0000;
   endfunction

   assign mem_di       = di_from_a ? di_of(mem_a) : di_fixed;
   assign strobes_idle = rom_cs_n & raml_cs_n & ramh_cs_n & mem_rd_n & mem_wr_n;

   wram_mem_arbiter #(
      .TIMEOUT       (4),
      .ROM_WR_IGNORE (1'b1)
   ) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .CE_R      (ce_r),
      .P0_REQ    (req[0]),
      .P0_WE     (we[0]),
      .P0_SEL    (sel[0]),
      .P0_A      (a[0]),
      .P0_D      (d[0]),
      .P0_DQM_N  (dqm_n[0]),
      .P0_Q      (q[0]),
      .P0_ACK    (ack[0]),
      .P1_REQ    (req[1]),
      .P1_WE     (we[1]),
      .P1_SEL    (sel[1]),
      .P1_A      (a[1]),
      .P1_D      (d[1]),
      .P1_DQM_N  (dqm_n[1]),
      .P1_Q      (q[1]),
      .P1_ACK    (ack[1]),
      .P2_REQ    (req[2]),
      .P2_WE     (we[2]),
      .P2_SEL    (sel[2]),
      .P2_A      (a[2]),
      .P2_D      (d[2]),
      .P2_DQM_N  (dqm_n[2]),
      .P2_Q      (q[2]),
      .P2_ACK    (ack[2]),
      .MEM_A     (mem_a),
      .MEM_DO    (mem_do),
      .MEM_DI    (mem_di),
      .MEM_DQM_N (mem_dqm_n),
      .MEM_RD_N  (mem_rd_n),
      .MEM_WR_N  (mem_wr_n),
      .ROM_CS_N  (rom_cs_n),
      .RAML_CS_N (raml_cs_n),
      .RAMH_CS_N (ramh_cs_n),
      .MEM_RDY   (mem_rdy),
      .TO_ERR    (to_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   always @(negedge clk) if (watch && !strobes_idle) saw_strobe = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Counts negedges until port p acknowledges, bounded by max.
   task automatic wait_ack(input int p, input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack[p] && n < max);
   endtask

   int  exp_ord [4] = '{0, 1, 2, 0};
   int  order [$];
   int  times [$];
   bit  first0;
   int  n;
   int  extra;

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      ce_r       = 1'b1;
      req        = '0;
      we         = '0;
      sel        = '0;
      a          = '0;
      d          = '0;
      dqm_n      = '1;
      mem_rdy    = 1'b0;
      di_from_a  = 1'b0;
      di_fixed   = '0;
      watch      = 1'b0;
      saw_strobe = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_do", mem_do, 0);
      check("rst_dqm", mem_dqm_n, 4'hF);
      check("rst_strobes", strobes_idle, 1);
      check("rst_ack", ack, 0);
      check("rst_q0", q[0], 0);
      check("rst_q2", q[2], 0);
      check("rst_to_err", to_err, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Contention from reset: 0,1,2 then P0 re-requests -> 0
      sel       = {2'd1, 2'd1, 2'd1};
      a[0]      = 25'h10;
      a[1]      = 25'h20;
      a[2]      = 25'h30;
      mem_rdy   = 1'b1;
      di_from_a = 1'b1;
      req       = 3'b111;
      first0    = 1'b1;
      for (int c = 0; c < 40 && order.size() < 4; c++) begin
         @(negedge clk);
         for (int p = 0; p < 3; p++) begin
            if (ack[p]) begin
               order.push_back(p);
               times.push_back(c);
               check("cont_q", q[p], di_of(a[p]));
               if (p == 0 && first0) begin
                  first0 = 1'b0;
                  a[0]   = 25'h1F0;
               end else begin
                  req[p] = 1'b0;
               end
            end
         end
      end
      req = '0;
      check("cont_n", order.size(), 4);
      if (times.size() > 0) check("cont_first", times[0], 2);
      foreach (order[i]) begin
         if (i < 4) check($sformatf("cont_ord%0d", i), order[i], exp_ord[i]);
         if (i > 0) check("cont_gap", times[i] - times[i-1], 4);
      end
      @(negedge clk);

      // Single read from RAML, RDY on the first WAIT cycle
      di_from_a = 1'b0;
      di_fixed  = 32'h1234_5678;
      mem_rdy   = 1'b0;
      a[0]      = 25'h0000100;
      sel[0]    = 2'd1;
      we[0]     = 1'b0;
      req[0]    = 1'b1;
      @(negedge clk);
      check("rd_cs_issue", raml_cs_n, 0);
      check("rd_rd_issue", mem_rd_n, 0);
      check("rd_wr_issue", mem_wr_n, 1);
      check("rd_addr", mem_a, 25'h100);
      check("rd_ack_early", ack, 0);
      mem_rdy = 1'b1;
      @(negedge clk);
      check("rd_cs_wait", raml_cs_n, 0);
      check("rd_rd_wait", mem_rd_n, 0);
      @(negedge clk);
      check("rd_ack", ack[0], 1);
      check("rd_q", q[0], 32'h1234_5678);
      check("rd_cs_done", raml_cs_n, 1);
      check("rd_rd_done", mem_rd_n, 1);
      req[0]  = 1'b0;
      mem_rdy = 1'b0;
      @(negedge clk);
      check("rd_ack_drop", ack[0], 0);
      check("rd_q_hold", q[0], 32'h1234_5678);

      // Byte write to RAMH, with a CE_R stall during the cycle
      we[2]    = 1'b1;
      sel[2]   = 2'd2;
      a[2]     = 25'h0ABCDE;
      d[2]     = 32'h0000_00AA;
      dqm_n[2] = 4'hE;
      mem_rdy  = 1'b1;
      req[2]   = 1'b1;
      @(negedge clk);
      check("wr_wr_n", mem_wr_n, 0);
      check("wr_rd_n", mem_rd_n, 1);
      check("wr_cs", ramh_cs_n, 0);
      check("wr_raml", raml_cs_n, 1);
      check("wr_dqm", mem_dqm_n, 4'hE);
      check("wr_do", mem_do, 32'h0000_00AA);
      check("wr_addr", mem_a, 25'h0ABCDE);
      ce_r = 1'b0;
      repeat (2) @(negedge clk);
      check("ce_hold_ack", ack, 0);
      check("ce_hold_wr", mem_wr_n, 0);
      ce_r = 1'b1;
      wait_ack(2, 10, n);
      check("wr_lat", n, 2);
      req[2] = 1'b0;
      extra  = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack[2]) extra++;
      end
      check("wr_ack_once", extra, 0);

      // Ignored ROM write and reserved-region read: no strobes, ACK at k+1
      saw_strobe = 1'b0;
      watch      = 1'b1;
      we[1]      = 1'b1;
      sel[1]     = 2'd0;
      a[1]       = 25'h40;
      req[1]     = 1'b1;
      @(negedge clk);
      check("romwr_ack", ack[1], 1);
      req[1] = 1'b0;
      @(negedge clk);
      check("romwr_ack_drop", ack[1], 0);
      we[0]  = 1'b0;
      sel[0] = 2'd3;
      req[0] = 1'b1;
      @(negedge clk);
      check("rsvd_ack", ack[0], 1);
      check("rsvd_q", q[0], 32'hFFFF_FFFF);
      req[0] = 1'b0;
      @(negedge clk);
      watch = 1'b0;
      check("skip_no_strobe", saw_strobe, 0);

      // Timeout on a read: 4 WAIT cycles, then dead read and sticky TO_ERR
      check("to_err_pre", to_err, 0);
      mem_rdy = 1'b0;
      sel[0]  = 2'd1;
      a[0]    = 25'h555;
      req[0]  = 1'b1;
      wait_ack(0, 20, n);
      check("to_lat", n, 6);
      check("to_q", q[0], 32'hFFFF_FFFF);
      check("to_err_set", to_err, 1);
      check("to_strobes", strobes_idle, 1);
      req[0] = 1'b0;
      @(negedge clk);
      di_from_a = 1'b1;
      mem_rdy   = 1'b1;
      we[1]     = 1'b0;
      sel[1]    = 2'd1;
      a[1]      = 25'h0123456;
      req[1]    = 1'b1;
      wait_ack(1, 20, n);
      check("good_lat", n, 3);
      check("good_q", q[1], di_of(25'h0123456));
      check("to_err_sticky", to_err, 1);
      req[1] = 1'b0;
      @(negedge clk);

      // Reset during WAIT: strobes drop at once, no ACK, port 0 first afterwards
      mem_rdy = 1'b0;
      req[1]  = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_cs_low", raml_cs_n, 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_strobes", strobes_idle, 1);
      check("mid_rst_ack", ack, 0);
      req = '0;
      @(negedge clk);
      check("mid_rst_ack2", ack, 0);
      check("mid_rst_to_err", to_err, 0);
      rst_n = 1'b1;
      @(negedge clk);
      sel     = {2'd1, 2'd1, 2'd1};
      we      = '0;
      mem_rdy = 1'b1;
      req     = 3'b110;
      req[0]  = 1'b1;
      wait_ack(0, 10, n);
      check("post_rst_p0_first", n, 3);
      req = '0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
